// File: rtl/seg_shift_rx.sv
// Loopback receiver for the seven-segment shift chain: oversamples seg_clk/seg_sout/SEG_PEN/seg_clrn
// and rebuilds each committed frame with length and overrun checking. Optional SEG_SHIFT_RX_FILTER_EN adds a 3-sample glitch filter.
module seg_shift_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  seg_clk,
  input  logic                  seg_sout,
  input  logic                  SEG_PEN,
  input  logic                  seg_clrn,
  input  logic                  frame_ack,
  input  logic                  err_clr,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic [6:0]            bit_cnt,
  output logic                  err_len,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [6:0] CNT_FULL = 7'(FRAME_BITS);
  localparam logic [6:0] CNT_SAT  = 7'(FRAME_BITS + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit order in each synchronizer word: {clrn, pen, sout, clk}
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_out;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {seg_clrn, SEG_PEN, seg_sout, seg_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  logic clk_rise;
  logic pen_rise;
  logic sout_s;
  logic clrn_s;

  assign clrn_s = sync_out[3];

`ifdef SEG_SHIFT_RX_FILTER_EN
  // A level is accepted only once three consecutive samples agree; sout is delayed to stay aligned with clk.
  logic [1:0] clk_win_q;
  logic [1:0] pen_win_q;
  logic [1:0] sout_dly_q;
  logic       clk_filt_q;
  logic       pen_filt_q;
  logic       clk_filt_d;
  logic       pen_filt_d;

  always_comb begin
    clk_filt_d = clk_filt_q;
    pen_filt_d = pen_filt_q;
    if (&{sync_out[0], clk_win_q})       clk_filt_d = 1'b1;
    else if (~|{sync_out[0], clk_win_q}) clk_filt_d = 1'b0;
    if (&{sync_out[2], pen_win_q})       pen_filt_d = 1'b1;
    else if (~|{sync_out[2], pen_win_q}) pen_filt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      clk_win_q  <= '0;
      pen_win_q  <= '0;
      sout_dly_q <= '0;
      clk_filt_q <= 1'b0;
      pen_filt_q <= 1'b0;
    end else begin
      clk_win_q  <= {clk_win_q[0], sync_out[0]};
      pen_win_q  <= {pen_win_q[0], sync_out[2]};
      sout_dly_q <= {sout_dly_q[0], sync_out[1]};
      clk_filt_q <= clk_filt_d;
      pen_filt_q <= pen_filt_d;
    end
  end

  assign clk_rise = clk_filt_d & ~clk_filt_q;
  assign pen_rise = pen_filt_d & ~pen_filt_q;
  assign sout_s   = sout_dly_q[1];
`else
  logic clk_hist_q;
  logic pen_hist_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      clk_hist_q <= 1'b0;
      pen_hist_q <= 1'b0;
    end else begin
      clk_hist_q <= sync_out[0];
      pen_hist_q <= sync_out[2];
    end
  end

  assign clk_rise = sync_out[0] & ~clk_hist_q;
  assign pen_rise = sync_out[2] & ~pen_hist_q;
  assign sout_s   = sync_out[1];
`endif

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [6:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;

  logic [FRAME_BITS-1:0] commit_shreg;
  logic [6:0]            commit_cnt;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    valid_d      = valid_q & ~frame_ack;
    err_d        = err_q & ~err_clr;
    ovr_d        = ovr_q & ~err_clr;
    commit_shreg = shreg_q;
    commit_cnt   = cnt_q;

    if (!clrn_s) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      // A shift in the commit cycle is applied first so the commit sees that bit.
      if (clk_rise) begin
        commit_shreg = {shreg_q[FRAME_BITS-2:0], sout_s};
        commit_cnt   = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 7'd1;
        shreg_d      = commit_shreg;
        cnt_d        = commit_cnt;
      end

      case (state_q)
        ST_IDLE:  if (clk_rise) state_d = ST_SHIFT;
        ST_SHIFT: state_d = ST_SHIFT;
        default:  state_d = ST_IDLE;
      endcase

      if (pen_rise) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (commit_cnt == CNT_FULL) begin
          frame_d = commit_shreg;
          valid_d = 1'b1;
          if (valid_q && !frame_ack) ovr_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // busy is a straight decode of the one-bit state register, so it doubles as the FSM state view.
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign bit_cnt     = cnt_q;
  assign err_len     = err_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_seg_shift_rx.sv
// Bench for seg_shift_rx: directed vector table, hand-written corner sequences, then random frames
// against a frame-level reference model.
module tb_seg_shift_rx;

  localparam int PH = 5;
`ifdef SEG_SHIFT_RX_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        RSTN;
  logic        seg_clk, seg_sout, SEG_PEN, seg_clrn, frame_ack, err_clr;
  logic [63:0] frame;
  logic        frame_valid;
  logic [6:0]  bit_cnt;
  logic        err_len, overrun, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [63:0] m_frame;
  logic        m_valid, m_err, m_ovr;

  seg_shift_rx dut (
    .clk(clk), .RSTN(RSTN), .seg_clk(seg_clk), .seg_sout(seg_sout), .SEG_PEN(SEG_PEN),
    .seg_clrn(seg_clrn), .frame_ack(frame_ack), .err_clr(err_clr), .frame(frame),
    .frame_valid(frame_valid), .bit_cnt(bit_cnt), .err_len(err_len), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbits;
    logic [127:0] data;
    bit          ack_after;
    bit          clr_after;
    logic [6:0]  exp_cnt;
    logic [63:0] exp_frame;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_ovr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    seg_clk  = 1'b0;
    seg_sout = b;
    cyc(PH);
    seg_clk = 1'b1;
    cyc(PH);
  endtask

  task automatic send_bits(input logic [127:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(d[i]);
  endtask

  task automatic commit(input bit ack_cc, input bit clr_cc);
    SEG_PEN = 1'b1;
    cyc(LAT);
    frame_ack = ack_cc;
    err_clr   = clr_cc;
    cyc(1);
    frame_ack = 1'b0;
    err_clr   = 1'b0;
    cyc(3);
    SEG_PEN = 1'b0;
    cyc(PH);
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    cyc(1);
    frame_ack = 1'b0;
    chk("valid_after_ack", 64'(frame_valid), 64'(0));
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("err_after_clr", 64'(err_len), 64'(0));
    chk("ovr_after_clr", 64'(overrun), 64'(0));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_frame"}, frame, 64'(0));
    chk({nm, "_valid"}, 64'(frame_valid), 64'(0));
    chk({nm, "_cnt"}, 64'(bit_cnt), 64'(0));
    chk({nm, "_err"}, 64'(err_len), 64'(0));
    chk({nm, "_ovr"}, 64'(overrun), 64'(0));
    chk({nm, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [127:0] d;
    int           n, k;
    bit           ack_cc, clr_cc, good;

    tbl[0] = '{64, 128'hA5A5_0F0F_1234_5678, 1'b1, 1'b0, 7'd64, 64'hA5A5_0F0F_1234_5678, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{63, 128'h0, 1'b0, 1'b0, 7'd63, 64'hA5A5_0F0F_1234_5678, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{70, 128'h3F_0123_4567_89AB_CDEF, 1'b0, 1'b1, 7'd65, 64'hA5A5_0F0F_1234_5678, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{64, 128'h1, 1'b0, 1'b0, 7'd64, 64'h1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{64, 128'h2, 1'b1, 1'b1, 7'd64, 64'h2, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{64, 128'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 7'd64, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 1'b0};

    // reset held with inputs toggling
    RSTN = 1'b0;
    seg_clk = 1'b0; seg_sout = 1'b0; SEG_PEN = 1'b0; seg_clrn = 1'b1;
    frame_ack = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seg_clk  = 1'($urandom_range(0, 1));
      seg_sout = 1'($urandom_range(0, 1));
      SEG_PEN  = 1'($urandom_range(0, 1));
      seg_clrn = 1'($urandom_range(0, 1));
      cyc(1);
    end
    chk_zero("in_reset");
    seg_clk = 1'b0; seg_sout = 1'b0; SEG_PEN = 1'b0; seg_clrn = 1'b1;
    cyc(2);
    RSTN = 1'b1;
    cyc(10);
    chk_zero("post_reset");

    // directed vector table
    for (int v = 0; v < 6; v++) begin
      send_bits(tbl[v].data, tbl[v].nbits);
      chk($sformatf("v%0d_cnt_pre", v), 64'(bit_cnt), 64'(tbl[v].exp_cnt));
      chk($sformatf("v%0d_busy_pre", v), 64'(busy), 64'(1));
      commit(1'b0, 1'b0);
      chk($sformatf("v%0d_frame", v), frame, tbl[v].exp_frame);
      chk($sformatf("v%0d_valid", v), 64'(frame_valid), 64'(tbl[v].exp_valid));
      chk($sformatf("v%0d_err", v), 64'(err_len), 64'(tbl[v].exp_err));
      chk($sformatf("v%0d_ovr", v), 64'(overrun), 64'(tbl[v].exp_ovr));
      chk($sformatf("v%0d_cnt_post", v), 64'(bit_cnt), 64'(0));
      chk($sformatf("v%0d_busy_post", v), 64'(busy), 64'(0));
      if (tbl[v].ack_after) begin
        frame_ack = 1'b1;
        #1 chk($sformatf("v%0d_valid_before_edge", v), 64'(frame_valid), 64'(1));
        cyc(1);
        frame_ack = 1'b0;
        chk($sformatf("v%0d_valid_acked", v), 64'(frame_valid), 64'(0));
      end
      if (tbl[v].clr_after) clr_pulse();
    end

    // ack in commit cycle: ack hits the old frame, no overrun, new frame stays valid
    send_bits(128'h4, 64);
    commit(1'b1, 1'b0);
    chk("ackcc_frame", frame, 64'h4);
    chk("ackcc_valid", 64'(frame_valid), 64'(1));
    chk("ackcc_ovr", 64'(overrun), 64'(0));
    ack_pulse();

    // err_clr in the same cycle as a new length error
    send_bits(128'h2AB, 10);
    commit(1'b0, 1'b1);
    chk("clrcc_err", 64'(err_len), 64'(1));
    chk("clrcc_frame", frame, 64'h4);
    clr_pulse();

    // zero-length commit from idle
    commit(1'b0, 1'b0);
    chk("zero_len_err", 64'(err_len), 64'(1));
    chk("zero_len_valid", 64'(frame_valid), 64'(0));
    clr_pulse();

    // chain clear in the middle of a frame
    send_bits(128'h3FFF_FFFF, 30);
    seg_clrn = 1'b0;
    cyc(LAT + 1);
    chk("clrn_busy", 64'(busy), 64'(0));
    chk("clrn_cnt", 64'(bit_cnt), 64'(0));
    chk("clrn_frame_kept", frame, 64'h4);
    cyc(2);
    seg_clrn = 1'b1;
    cyc(PH);
    send_bits(128'h0123_4567_89AB_CDEF, 64);
    commit(1'b0, 1'b0);
    chk("clrn_frame", frame, 64'h0123_4567_89AB_CDEF);
    chk("clrn_err", 64'(err_len), 64'(0));
    chk("clrn_valid", 64'(frame_valid), 64'(1));
    ack_pulse();

    // seg_clk and SEG_PEN rise together on the 64th bit
    d = 128'hFEDC_BA98_7654_3211;
    send_bits(d >> 1, 63);
    seg_clk = 1'b0;
    seg_sout = d[0];
    cyc(PH);
    seg_clk = 1'b1;
    SEG_PEN = 1'b1;
    cyc(PH);
    SEG_PEN = 1'b0;
    cyc(PH);
    chk("same_frame", frame, 64'hFEDC_BA98_7654_3211);
    chk("same_err", 64'(err_len), 64'(0));
    chk("same_cnt", 64'(bit_cnt), 64'(0));
    chk("same_valid", 64'(frame_valid), 64'(1));

    // reset mid-frame
    send_bits(128'hFFFFF, 20);
    RSTN = 1'b0;
    #1;
    chk_zero("mid_reset");
    seg_clk = 1'b0;
    seg_sout = 1'b0;
    cyc(3);
    RSTN = 1'b1;
    cyc(5);
    chk_zero("mid_reset_rel");

    // random frames against the frame-level model
    m_frame = '0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 40);
        send_bits({$urandom, $urandom, $urandom, $urandom}, k);
        seg_clrn = 1'b0;
        cyc(LAT + 2);
        seg_clrn = 1'b1;
        cyc(PH);
        chk("rnd_clrn_cnt", 64'(bit_cnt), 64'(0));
      end
      n = ($urandom_range(0, 2) == 0) ? $urandom_range(60, 68) : 64;
      d = {$urandom, $urandom, $urandom, $urandom};
      ack_cc = ($urandom_range(0, 3) == 0);
      clr_cc = ($urandom_range(0, 3) == 0);
      send_bits(d, n);
      chk("rnd_cnt_pre", 64'(bit_cnt), 64'((n > 65) ? 65 : n));
      commit(ack_cc, clr_cc);

      good = (n == 64);
      m_ovr   = (m_ovr & ~clr_cc) | (good & m_valid & ~ack_cc);
      m_err   = (m_err & ~clr_cc) | ~good;
      m_valid = good ? 1'b1 : (m_valid & ~ack_cc);
      if (good) m_frame = d[63:0];

      chk("rnd_frame", frame, m_frame);
      chk("rnd_valid", 64'(frame_valid), 64'(m_valid));
      chk("rnd_err", 64'(err_len), 64'(m_err));
      chk("rnd_ovr", 64'(overrun), 64'(m_ovr));
      chk("rnd_cnt_post", 64'(bit_cnt), 64'(0));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        clr_pulse();
        m_err = 1'b0;
        m_ovr = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
